// File: rtl/message_fetch_pkg.sv
// Shared types for the message fetch path: FSM state encoding and the
// {last, byte} beat carried through the output skid buffer.
package message_fetch_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOC_RD,
        LOC_WAIT,
        STREAM
    } fetch_state_e;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fetch_beat_t;

endpackage

// File: rtl/message_fetch_skid.sv
// Two-entry output FIFO with fall-through: a returning byte goes straight out
// when the FIFO is empty and downstream is ready, otherwise it is stored.
module message_fetch_skid
    import message_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    input  fetch_beat_t in_beat_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output fetch_beat_t out_beat_o,
    input  logic        out_ready_i,
    output logic [1:0]  count_o
);

    fetch_beat_t mem_q [2];
    fetch_beat_t mem_d [2];
    logic [1:0]  count_q, count_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        empty, push, pop;

    always_comb begin
        empty   = (count_q == 2'd0);
        push    = in_valid_i && !(empty && out_ready_i);
        pop     = !empty && out_ready_i;
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = in_beat_i;
        wr_d    = wr_q ^ push;
        rd_d    = rd_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        in_ready_o  = (count_q != 2'd2);
        out_valid_o = !empty || in_valid_i;
        // Outputs are forced to zero when nothing is valid.
        if (!empty)          out_beat_o = mem_q[rd_q];
        else if (in_valid_i) out_beat_o = in_beat_i;
        else                 out_beat_o = '0;
        count_o = count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/message_fetch.sv
// Looks up a message's [start, end] byte range in the location RAMs, then
// streams those bytes from the circular byte buffer with valid/ready/last.
module message_fetch
    import message_fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_MESSAGE = 10,
    parameter int BYTE_WIDTH  = BYTE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    input  logic [NUM_MESSAGE-1:0] req_idx_i,
    output logic                   req_ready_o,
    output logic                   loc_re_o,
    output logic                   loc_read_start_o,
    output logic                   loc_read_end_o,
    output logic [NUM_MESSAGE-1:0] loc_addr_o,
    input  logic [DATA_WIDTH-1:0]  loc_start_i,
    input  logic [DATA_WIDTH-1:0]  loc_end_i,
    output logic                   buf_re_o,
    output logic [DATA_WIDTH-1:0]  buf_addr_o,
    input  logic [BYTE_WIDTH-1:0]  buf_data_i,
    output logic                   out_valid_o,
    output logic [BYTE_WIDTH-1:0]  out_data_o,
    output logic                   out_last_o,
    input  logic                   out_ready_i,
    output logic                   busy_o
);

    fetch_state_e           state_q, state_d;
    logic                   loc_re_q, loc_re_d;
    logic [NUM_MESSAGE-1:0] loc_addr_q, loc_addr_d;
    logic [DATA_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]  end_ptr_q, end_ptr_d;
    logic                   issue_done_q, issue_done_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;

    logic                   buf_re;
    logic                   skid_in_ready;
    logic [1:0]             skid_cnt;
    fetch_beat_t            ret_beat;
    fetch_beat_t            out_beat;
    logic                   out_valid;

    message_fetch_skid u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_beat_i   (ret_beat),
        .in_ready_o  (skid_in_ready),
        .out_valid_o (out_valid),
        .out_beat_o  (out_beat),
        .out_ready_i (out_ready_i),
        .count_o     (skid_cnt)
    );

    always_comb begin
        state_d         = state_q;
        loc_re_d        = 1'b0;
        loc_addr_d      = '0;
        rd_ptr_d        = rd_ptr_q;
        end_ptr_d       = end_ptr_q;
        issue_done_d    = issue_done_q;
        buf_re          = 1'b0;
        ret_beat.last   = inflight_last_q;
        ret_beat.data   = buf_data_i;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d    = LOC_RD;
                    loc_re_d   = 1'b1;
                    loc_addr_d = req_idx_i;
                end
            end
            LOC_RD: state_d = LOC_WAIT;
            LOC_WAIT: begin
                rd_ptr_d     = loc_start_i;
                end_ptr_d    = loc_end_i;
                issue_done_d = 1'b0;
                state_d      = STREAM;
            end
            STREAM: begin
                // Stored plus in-flight bytes never exceed the two skid slots.
                buf_re = !issue_done_q && skid_in_ready &&
                         ((skid_cnt + {1'b0, inflight_q}) < 2'd2);
                if (buf_re) begin
                    if (rd_ptr_q == end_ptr_q) issue_done_d = 1'b1;
                    else                       rd_ptr_d     = rd_ptr_q + 1'b1;
                end
                if (out_valid && out_ready_i && out_beat.last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inflight_d      = buf_re;
        inflight_last_d = buf_re && (rd_ptr_q == end_ptr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            loc_re_q        <= 1'b0;
            loc_addr_q      <= '0;
            rd_ptr_q        <= '0;
            end_ptr_q       <= '0;
            issue_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            loc_re_q        <= loc_re_d;
            loc_addr_q      <= loc_addr_d;
            rd_ptr_q        <= rd_ptr_d;
            end_ptr_q       <= end_ptr_d;
            issue_done_q    <= issue_done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign loc_re_o         = loc_re_q;
    assign loc_read_start_o = loc_re_q;
    assign loc_read_end_o   = loc_re_q;
    assign loc_addr_o       = loc_addr_q;
    assign buf_re_o         = buf_re;
    assign buf_addr_o       = buf_re ? rd_ptr_q : '0;
    assign out_valid_o      = out_valid;
    assign out_data_o       = out_beat.data;
    assign out_last_o       = out_beat.last;

endmodule

// File: tb/tb_message_fetch.sv
// Randomized scoreboard bench for message_fetch: bench-side location/byte
// RAMs, expected bytes derived from the (end-start) mod 2**DW + 1 rule.
module tb_message_fetch;

    localparam int DW   = 5;
    localparam int NM   = 10;
    localparam int BW   = 8;
    localparam int BUFN = 1 << DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [NM-1:0] req_idx_i = '0;
    logic          req_ready_o;
    logic          loc_re_o, loc_read_start_o, loc_read_end_o;
    logic [NM-1:0] loc_addr_o;
    logic [DW-1:0] loc_start_i = '0;
    logic [DW-1:0] loc_end_i = '0;
    logic          buf_re_o;
    logic [DW-1:0] buf_addr_o;
    logic [BW-1:0] buf_data_i = '0;
    logic          out_valid_o;
    logic [BW-1:0] out_data_o;
    logic          out_last_o;
    logic          out_ready_i = 1'b1;
    logic          busy_o;

    message_fetch #(.DATA_WIDTH(DW), .NUM_MESSAGE(NM), .BYTE_WIDTH(BW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_idx_i(req_idx_i), .req_ready_o(req_ready_o),
        .loc_re_o(loc_re_o), .loc_read_start_o(loc_read_start_o), .loc_read_end_o(loc_read_end_o),
        .loc_addr_o(loc_addr_o), .loc_start_i(loc_start_i), .loc_end_i(loc_end_i),
        .buf_re_o(buf_re_o), .buf_addr_o(buf_addr_o), .buf_data_i(buf_data_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    initial forever #5 clk = ~clk;

    // Bench-side memories
    logic [DW-1:0] loc_s [1 << NM];
    logic [DW-1:0] loc_e [1 << NM];
    logic [BW-1:0] bmem  [BUFN];

    always @(posedge clk) begin
        if (loc_re_o) begin
            loc_start_i <= loc_s[loc_addr_o];
            loc_end_i   <= loc_e[loc_addr_o];
        end
        if (buf_re_o) buf_data_i <= bmem[buf_addr_o];
    end

    typedef struct packed { logic [BW-1:0] d; logic l; } exp_t;
    exp_t exp_q [$];
    int   addr_q [$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int accepts = 0, dones = 0;
    int beat = 0, acc_cyc = 0, cur_len = 0, cur_idx = 0;
    int issued = 0, hs = 0, max_out = 0;
    int mode = 0;
    bit timed = 0, active = 0, chk_ready_next = 0, stall = 0;
    logic [BW-1:0] stall_d;
    logic          stall_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int got);
        checks++;
        errors++;
        $display("FAIL %s got=%0d cycle=%0d", name, got, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("last_without_valid", {31'd0, out_last_o & ~out_valid_o}, 0);
            if (stall) begin
                chk("stall_valid", {31'd0, out_valid_o}, 1);
                chk("stall_data", {24'd0, out_data_o}, {24'd0, stall_d});
                chk("stall_last", {31'd0, out_last_o}, {31'd0, stall_l});
            end
            if (chk_ready_next) begin
                chk("ready_after_last", {31'd0, req_ready_o}, 1);
                chk("busy_after_last", {31'd0, busy_o}, 0);
                chk_ready_next = 0;
            end else if (active) begin
                chk("ready_while_busy", {31'd0, req_ready_o}, 0);
                chk("busy_while_active", {31'd0, busy_o}, 1);
            end
            if (loc_re_o) begin
                chk("loc_addr", {22'd0, loc_addr_o}, cur_idx);
                chk("loc_cycle", cyc, acc_cyc + 1);
                chk("loc_rd_flags", {30'd0, loc_read_start_o, loc_read_end_o}, 3);
            end
            if (buf_re_o) begin
                issued++;
                if (addr_q.size() == 0) fail("unexpected_buf_read", int'(buf_addr_o));
                else chk("buf_addr", {27'd0, buf_addr_o}, addr_q.pop_front());
            end
            if (out_valid_o && out_ready_i) begin
                exp_t e;
                hs++;
                beat++;
                if (exp_q.size() == 0) fail("unexpected_beat", int'(out_data_o));
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data_o}, {24'd0, e.d});
                    chk("out_last", {31'd0, out_last_o}, {31'd0, e.l});
                end
                if (timed && beat == 1) chk("first_beat_cycle", cyc, acc_cyc + 4);
                if (out_last_o) begin
                    if (timed) chk("last_beat_cycle", cyc, acc_cyc + 3 + cur_len);
                    chk("max_outstanding", max_out, (max_out <= 2) ? max_out : 2);
                    active = 0;
                    chk_ready_next = 1;
                    dones++;
                end
            end
            if (issued - hs > max_out) max_out = issued - hs;
            stall   = out_valid_o && !out_ready_i;
            stall_d = out_data_o;
            stall_l = out_last_o;
            if (req_valid_i && req_ready_o) begin
                int s, en;
                chk("accept_while_active", {31'd0, active}, 0);
                cur_idx = int'(req_idx_i);
                acc_cyc = cyc;
                timed   = (mode == 0);
                beat = 0; issued = 0; hs = 0; max_out = 0;
                s  = int'(loc_s[req_idx_i]);
                en = int'(loc_e[req_idx_i]);
                cur_len = ((en - s + BUFN) % BUFN) + 1;
                for (int i = 0; i < cur_len; i++) begin
                    int a;
                    a = (s + i) % BUFN;
                    exp_q.push_back('{d: bmem[a], l: (i == cur_len - 1)});
                    addr_q.push_back(a);
                end
                active = 1;
                accepts++;
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = 1,0,0 pattern, 2 = random
    initial begin
        int pat;
        pat = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready_i = 1'b1;
                1: begin out_ready_i = (pat == 0); pat = (pat + 1) % 3; end
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_acc(input int tgt);
        int n;
        n = 0;
        while (accepts < tgt && n < 200) begin @(posedge clk); #1; n++; end
        if (accepts < tgt) fail("accept_timeout", accepts);
    endtask

    task automatic wait_done(input int tgt);
        int n;
        n = 0;
        while (dones < tgt && n < 400) begin @(posedge clk); #1; n++; end
        if (dones < tgt) fail("done_timeout", dones);
    endtask

    task automatic run_msg(input int idx, input int m);
        int at, dt;
        mode = m;
        at = accepts + 1;
        dt = dones + 1;
        @(posedge clk); #1;
        req_valid_i = 1'b1;
        req_idx_i   = NM'(idx);
        wait_acc(at);
        req_valid_i = 1'b0;
        wait_done(dt);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", {31'd0, req_ready_o}, 1);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 0);
        chk("rst_out_last", {31'd0, out_last_o}, 0);
        chk("rst_out_data", {24'd0, out_data_o}, 0);
        chk("rst_loc", {29'd0, loc_re_o, loc_read_start_o, loc_read_end_o}, 0);
        chk("rst_loc_addr", {22'd0, loc_addr_o}, 0);
        chk("rst_buf", {26'd0, buf_re_o, buf_addr_o}, 0);
    endtask

    initial begin
        int at, dt, bt, n;
        for (int i = 0; i < (1 << NM); i++) begin
            loc_s[i] = DW'($urandom);
            loc_e[i] = DW'($urandom);
        end
        for (int i = 0; i < BUFN; i++) bmem[i] = BW'($urandom);

        #1;
        chk_reset_vals();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Basic fetch
        loc_s[3] = 5'd4; loc_e[3] = 5'd7;
        bmem[4] = 8'h38; bmem[5] = 8'h3D; bmem[6] = 8'h46; bmem[7] = 8'h49;
        run_msg(3, 0);
        // Single byte
        loc_s[5] = 5'd10; loc_e[5] = 5'd10; bmem[10] = 8'h01;
        run_msg(5, 0);
        // Wrap around the circular buffer
        loc_s[9] = 5'd30; loc_e[9] = 5'd1;
        run_msg(9, 0);
        // Backpressure, 6 bytes
        loc_s[12] = 5'd20; loc_e[12] = 5'd25;
        run_msg(12, 1);

        // Busy rejection: second request held during streaming
        loc_s[20] = 5'd0; loc_e[20] = 5'd5;
        loc_s[21] = 5'd8; loc_e[21] = 5'd9;
        mode = 0;
        at = accepts; dt = dones;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_idx_i = NM'(20);
        wait_acc(at + 1);
        req_idx_i = NM'(21);
        wait_acc(at + 2);
        chk("second_accept_after_first_done", dones, dt + 1);
        req_valid_i = 1'b0;
        wait_done(dt + 2);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a 5-byte message
        loc_s[30] = 5'd14; loc_e[30] = 5'd18;
        mode = 0;
        at = accepts;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_idx_i = NM'(30);
        wait_acc(at + 1);
        req_valid_i = 1'b0;
        n = 0;
        while (beat < 2 && n < 100) begin @(posedge clk); n++; end
        if (beat < 2) fail("reset_wait_timeout", beat);
        bt = beat;
        #1 rst = 1'b0;
        #1;
        chk_reset_vals();
        chk("beats_before_reset", bt, 2);
        exp_q.delete();
        addr_q.delete();
        active = 0; chk_ready_next = 0; stall = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_msg(3, 0);

        // Randomized messages
        for (int k = 0; k < 25; k++) begin
            int idx;
            idx = int'($urandom_range(0, (1 << NM) - 1));
            loc_s[idx] = DW'($urandom);
            loc_e[idx] = DW'($urandom);
            run_msg(idx, int'($urandom_range(0, 2)));
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
